// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: word widths, instruction codes,
// and helpers that decode an icode into address/data sources and access flags.
package mem_stage_pkg;

    localparam int DATA_WID  = 64;
    localparam int ICODE_WID = 4;

    typedef logic [ICODE_WID-1:0] icode_t;

    // Instruction codes that touch data memory
    localparam icode_t IRMMOVQ = 4'h4;
    localparam icode_t IMRMOVQ = 4'h5;
    localparam icode_t ICALL   = 4'h8;
    localparam icode_t IRET    = 4'h9;
    localparam icode_t IPUSHQ  = 4'hA;
    localparam icode_t IPOPQ   = 4'hB;

    // Where the memory address comes from
    typedef enum logic [1:0] {
        ASRC_NONE = 2'd0,
        ASRC_VALE = 2'd1,
        ASRC_VALA = 2'd2
    } addr_src_t;

    // Where the write data comes from
    typedef enum logic [1:0] {
        DSRC_NONE = 2'd0,
        DSRC_VALA = 2'd1,
        DSRC_VALP = 2'd2
    } data_src_t;

    // Read/write request pair; never both set for the same icode
    typedef struct packed {
        logic rd;
        logic wr;
    } mem_flags_t;

    // Stores and calls/pushes address through valE; ret/pop use the old stack
    // pointer carried in valA.
    function automatic addr_src_t addr_src(input icode_t ic);
        addr_src_t src;
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL, IPUSHQ: src = ASRC_VALE;
            IRET, IPOPQ:                     src = ASRC_VALA;
            default:                         src = ASRC_NONE;
        endcase
        return src;
    endfunction

    // Register stores write valA; call pushes the return address valP.
    function automatic data_src_t data_src(input icode_t ic);
        data_src_t src;
        case (ic)
            IRMMOVQ, IPUSHQ: src = DSRC_VALA;
            ICALL:           src = DSRC_VALP;
            default:         src = DSRC_NONE;
        endcase
        return src;
    endfunction

    // Loads read, stores write, everything else (including undefined codes) idles.
    function automatic mem_flags_t mem_flags(input icode_t ic);
        mem_flags_t f;
        f = '0;
        case (ic)
            IMRMOVQ, IRET, IPOPQ:   f.rd = 1'b1;
            IRMMOVQ, ICALL, IPUSHQ: f.wr = 1'b1;
            default:                f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed data memory with asynchronous clear, combinational read and
// a range check that both flags the error and suppresses the access.
module data_mem_array #(
    parameter int DATA_WID = 64,
    parameter int DEPTH    = 256
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_WID-1:0] addr,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                write_flag,
    input  logic                read_flag,
    output logic [DATA_WID-1:0] valM,
    output logic                dmem_error
);

    // Index width; at least one bit so a single-word memory still elaborates
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WID-1:0] mem_reg [DEPTH];
    logic [AW-1:0]       idx;
    logic                in_range;
    logic                write_en;

    assign idx      = addr[AW-1:0];
    assign in_range = (addr < DATA_WID'(DEPTH));

    // Error only matters when an access is actually requested
    always_comb begin
        dmem_error = (read_flag || write_flag) && !in_range;
    end

    // Out-of-range stores are dropped rather than aliased onto a low word
    always_comb begin
        write_en = write_flag && in_range;
    end

    // Storage: reset wipes every word, otherwise accept one in-range write
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (write_en) begin
            mem_reg[idx] <= write_data;
        end
    end

    // Zero-latency read; idle or faulting accesses return zero
    always_comb begin
        valM = '0;
        if (read_flag && in_range) begin
            valM = mem_reg[idx];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the pipeline: selects address and store data from the
// instruction code, decodes read/write intent and drives the data memory.
module mem_stage #(
    parameter int DATA_WID  = mem_stage_pkg::DATA_WID,
    parameter int ICODE_WID = mem_stage_pkg::ICODE_WID,
    parameter int DEPTH     = 256
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ICODE_WID-1:0] icode,
    input  logic [DATA_WID-1:0]  valE,
    input  logic [DATA_WID-1:0]  valA,
    input  logic [DATA_WID-1:0]  valP,
    output logic [DATA_WID-1:0]  valM,
    output logic                 dmem_error,
    output logic [DATA_WID-1:0]  mem_addr,
    output logic [DATA_WID-1:0]  mem_data
);

    import mem_stage_pkg::*;

    mem_flags_t flags;
    logic       read_flag;
    logic       write_flag;

    // Address mux: valE for base+disp / pre-decrement, valA for post-increment pops
    always_comb begin
        mem_addr = '0;
        case (addr_src(icode))
            ASRC_VALE: mem_addr = valE;
            ASRC_VALA: mem_addr = valA;
            default:   mem_addr = '0;
        endcase
    end

    // Store-data mux: register value for stores/pushes, return address for calls
    always_comb begin
        mem_data = '0;
        case (data_src(icode))
            DSRC_VALA: mem_data = valA;
            DSRC_VALP: mem_data = valP;
            default:   mem_data = '0;
        endcase
    end

    // Access decode; undefined codes fall through to no access
    always_comb begin
        flags      = mem_flags(icode);
        read_flag  = flags.rd;
        write_flag = flags.wr;
    end

    data_mem_array #(
        .DATA_WID (DATA_WID),
        .DEPTH    (DEPTH)
    ) u_data_mem_array (
        .CLK        (CLK),
        .RST        (RST),
        .addr       (mem_addr),
        .write_data (mem_data),
        .write_flag (write_flag),
        .read_flag  (read_flag),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver predicts each cycle's outputs from
// a word-array model and queues them; a negedge monitor compares the DUT.
module tb_mem_stage;

    localparam int DW    = 64;
    localparam int DEPTH = 256;

    logic          CLK;
    logic          RST;
    logic [3:0]    icode;
    logic [DW-1:0] valE, valA, valP;
    logic [DW-1:0] valM, mem_addr, mem_data;
    logic          dmem_error;

    typedef struct {
        string         tag;
        logic [3:0]    ic;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] valm;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [DEPTH];
    int            vectors     = 0;
    int            miscompares = 0;

    mem_stage #(
        .DATA_WID  (DW),
        .ICODE_WID (4),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .valM       (valM),
        .dmem_error (dmem_error),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one instruction for one cycle and queue the predicted outputs
    task automatic apply(input string tag, input logic [3:0] ic,
                         input logic [DW-1:0] e, input logic [DW-1:0] a,
                         input logic [DW-1:0] p);
        exp_t x;
        bit   is_rd, is_wr;
        @(posedge CLK);
        #1;
        icode = ic; valE = e; valA = a; valP = p;
        is_rd = ic inside {4'h5, 4'h9, 4'hB};
        is_wr = ic inside {4'h4, 4'h8, 4'hA};
        x.tag  = tag;
        x.ic   = ic;
        x.addr = (ic inside {4'h4, 4'h5, 4'h8, 4'hA}) ? e :
                 (ic inside {4'h9, 4'hB})             ? a : '0;
        x.data = (ic inside {4'h4, 4'hA}) ? a : (ic == 4'h8) ? p : '0;
        x.err  = (is_rd || is_wr) && (x.addr >= DEPTH);
        x.valm = (is_rd && !x.err) ? model[int'(x.addr)] : '0;
        exp_q.push_back(x);
        // The store lands on the coming edge, so later predictions see it
        if (is_wr && !x.err) model[int'(x.addr)] = x.data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Monitor: one comparison set per queued transaction, sampled mid-cycle
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            bit   bad;
            x   = exp_q.pop_front();
            bad = 1'b0;
            vectors++;
            if (mem_addr !== x.addr) begin
                $display("FAIL %s mem_addr got=%h want=%h", x.tag, mem_addr, x.addr);
                miscompares++; bad = 1'b1;
            end
            if (mem_data !== x.data) begin
                $display("FAIL %s mem_data got=%h want=%h", x.tag, mem_data, x.data);
                miscompares++; bad = 1'b1;
            end
            if (valM !== x.valm) begin
                $display("FAIL %s valM got=%h want=%h", x.tag, valM, x.valm);
                miscompares++; bad = 1'b1;
            end
            if (dmem_error !== x.err) begin
                $display("FAIL %s dmem_error got=%b want=%b", x.tag, dmem_error, x.err);
                miscompares++; bad = 1'b1;
            end
            if (!bad)
                $display("ok %s icode=%h addr=%h data=%h valM=%h err=%b",
                         x.tag, x.ic, mem_addr, mem_data, valM, dmem_error);
        end
    end

    initial begin
        logic [DW-1:0] ra, rd, rp;
        logic [3:0]    ric;
        RST = 1'b1; icode = '0; valE = '0; valA = '0; valP = '0;
        clear_model();
        #12 RST = 1'b0;

        // Reset state: every read returns zero
        for (int i = 0; i < 4; i++) apply("rst_read", 4'h5, DW'(i * 85), '0, '0);

        // Seven stores then a load of word 3
        for (int i = 1; i <= 7; i++) apply("rmmovq", 4'h4, DW'(i), DW'(i * 'h11), '0);
        apply("mrmovq3", 4'h5, 64'd3, '0, '0);

        // Push / pop pair
        apply("pushq", 4'hA, 64'd8, 64'h30, '0);
        apply("popq",  4'hB, '0, 64'd8, '0);

        // Call / ret pair
        apply("call", 4'h8, 64'd9, '0, 64'h99);
        apply("ret",  4'h9, '0, 64'd9, '0);

        // Non-memory icode leaves word 9 alone
        apply("opq", 4'h2, 64'd9, 64'd9, '0);
        apply("rd9", 4'h5, 64'd9, '0, '0);

        // Range boundary: last word works, one past it faults and is dropped
        apply("wr_last", 4'h4, 64'd255, 64'hDEAD_BEEF, '0);
        apply("rd_last", 4'h5, 64'd255, '0, '0);
        apply("oob_wr",  4'h4, 64'h100, 64'hAB, '0);
        apply("oob_rd",  4'h5, 64'h100, '0, '0);
        apply("oob_pop", 4'hB, '0, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        for (int i = 0; i < 10; i++) apply("scan", 4'h5, DW'(i), '0, '0);
        apply("scan_ff", 4'h5, 64'd255, '0, '0);

        // Reset pulse between edges wipes memory
        apply("wr5", 4'h4, 64'd5, 64'h55, '0);
        @(posedge CLK);
        #1 icode = 4'h0;
        #1 RST = 1'b1;
        clear_model();
        #2 RST = 1'b0;
        apply("rd5_after_rst", 4'h5, 64'd5, '0, '0);

        // Store held across an edge while in reset must not land
        @(posedge CLK);
        #1 RST = 1'b1; icode = 4'h4; valE = 64'd3; valA = 64'hEE;
        @(posedge CLK);
        #1 RST = 1'b0; icode = 4'h0;
        apply("rd3_held_rst", 4'h5, 64'd3, '0, '0);
        apply("wr_resume", 4'h4, 64'd3, 64'h1234, '0);
        apply("rd_resume", 4'h5, 64'd3, '0, '0);

        // Random traffic over all icodes, mostly in a small hot address window
        for (int n = 0; n < 300; n++) begin
            ric = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       ra = {$urandom, $urandom};
                1, 2:    ra = DW'($urandom_range(0, DEPTH + 2));
                default: ra = DW'($urandom_range(0, 15));
            endcase
            rd = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            if (ric inside {4'h9, 4'hB}) apply("rand", ric, rd, ra, rp);
            else                         apply("rand", ric, ra, rd, rp);
        end

        repeat (2) @(posedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain pending got=%0d want=0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
